exec_pipeline: RTL and testbench

- Parametrised three-stage execute core: issue/operand-read, execute (ALU), write-back.
- Generalises the single-cycle register-file + ALU core:
  - configurable data width and register count
  - register-register and register-immediate operands
  - full operand forwarding, so there are no stalls on data hazards
  - valid/ready handshakes on both the input and result sides
  - a retired-instruction counter
- Sits between the future decode stage and the memory/branch units.

---
 rtl/exec_pipeline.sv | 149 ++++++++++++++
 tb/tb_exec_pipeline.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_pipeline.sv
// Three-stage execute core (issue/operand-read, ALU, write-back) with full
// operand forwarding, valid/ready handshakes and a retired-instruction counter.
module exec_pipeline #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [AW-1:0]   dst,
  input  logic [AW-1:0]   src1,
  input  logic [AW-1:0]   src2,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_dst,
  output logic [XLEN-1:0] out_data,
  output logic [31:0]     retire_count,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_e;

  logic [XLEN-1:0] regs [NUM_REGS];

  logic            ex_valid;
  logic [3:0]      ex_op;
  logic [AW-1:0]   ex_dst;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;

  logic            wb_valid;
  logic [AW-1:0]   wb_dst;
  logic [XLEN-1:0] wb_data;

  logic            stall;
  logic            advance;
  logic            retire;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;
  logic [SW-1:0]   shamt;

  assign stall        = wb_valid && !out_ready;
  assign advance      = !stall;
  assign in_ready     = advance;
  assign retire       = wb_valid && out_ready;
  assign out_valid    = wb_valid;
  assign out_dst      = wb_dst;
  assign out_data     = wb_data;
  assign dbg_data     = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  assign shamt        = ex_b[SW-1:0];

  // Newest producer wins: EX is younger than WB, both younger than the file.
  function automatic logic [XLEN-1:0] fwd(
    input logic [AW-1:0]   src,
    input logic            exv,
    input logic [AW-1:0]   exd,
    input logic [XLEN-1:0] exr,
    input logic            wbv,
    input logic [AW-1:0]   wbd,
    input logic [XLEN-1:0] wbr,
    input logic [XLEN-1:0] rf
  );
    if (src == '0)                  return '0;
    else if (exv && exd == src)     return exr;
    else if (wbv && wbd == src)     return wbr;
    else                            return rf;
  endfunction

  always_comb begin
    opnd_a = fwd(src1, ex_valid, ex_dst, alu_res, wb_valid, wb_dst, wb_data, regs[src1]);
    opnd_b = use_imm ? imm
                     : fwd(src2, ex_valid, ex_dst, alu_res, wb_valid, wb_dst, wb_data, regs[src2]);
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_res = ex_a + ex_b;
    case (op_e'(ex_op))
      OP_SUB:  alu_res = ex_a - ex_b;
      OP_AND:  alu_res = ex_a & ex_b;
      OP_OR:   alu_res = ex_a | ex_b;
      OP_XOR:  alu_res = ex_a ^ ex_b;
      OP_SHL:  alu_res = ex_a << shamt;
      OP_SHR:  alu_res = ex_a >> shamt;
      OP_SRA:  alu_res = $signed(ex_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, ex_a < ex_b};
      default: alu_res = ex_a + ex_b;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values; the register file is reset too because architectural
  // state must read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_op        <= '0;
      ex_dst       <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      wb_valid     <= 1'b0;
      wb_dst       <= '0;
      wb_data      <= '0;
      retire_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (retire) begin
        retire_count <= retire_count + 32'd1;
        if (wb_dst != '0) regs[wb_dst] <= wb_data;
      end
      if (advance) begin
        ex_valid <= in_valid;
        if (in_valid) begin
          ex_op  <= op;
          ex_dst <= dst;
          ex_a   <= opnd_a;
          ex_b   <= opnd_b;
        end
        wb_valid <= ex_valid;
        if (ex_valid) begin
          wb_dst  <= ex_dst;
          wb_data <= alu_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_pipeline.sv
// Directed, table-driven bench for exec_pipeline: dependent chains, backpressure,
// zero register, ALU edges, reset mid-flight and an 8-bit parametric build.
module tb_exec_pipeline;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        use_imm;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  dst, src1, src2;
  logic        use_imm;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_dst;
  logic [31:0] out_data;
  logic [31:0] retire_count;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        p_in_valid, p_in_ready, p_use_imm, p_out_valid;
  logic [3:0]  p_op;
  logic [2:0]  p_dst, p_src1, p_src2, p_out_dst, p_dbg_addr;
  logic [7:0]  p_imm, p_out_data, p_dbg_data;
  logic [31:0] p_retire_count;

  int   checks = 0;
  int   errors = 0;
  int   exp_retire = 0;
  vec_t vecs[32];

  always #5 clk = ~clk;

  exec_pipeline dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .src1(src1), .src2(src2), .use_imm(use_imm), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst),
    .out_data(out_data), .retire_count(retire_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  exec_pipeline #(.XLEN(8), .NUM_REGS(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .op(p_op), .dst(p_dst), .src1(p_src1), .src2(p_src2), .use_imm(p_use_imm),
    .imm(p_imm), .out_valid(p_out_valid), .out_ready(1'b1), .out_dst(p_out_dst),
    .out_data(p_out_data), .retire_count(p_retire_count),
    .dbg_addr(p_dbg_addr), .dbg_data(p_dbg_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  function automatic vec_t mk(input int o, input int d, input int s1, input int s2,
                              input bit ui, input logic [31:0] im, input logic [31:0] ex);
    vec_t v;
    v.op = 4'(o); v.dst = 5'(d); v.src1 = 5'(s1); v.src2 = 5'(s2);
    v.use_imm = ui; v.imm = im; v.exp = ex;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; op = v.op; dst = v.dst; src1 = v.src1; src2 = v.src2;
    use_imm = v.use_imm; imm = v.imm;
  endtask

  // Issues vecs[first +: n] back-to-back; each result is due two edges after issue.
  task automatic run_table(input string tag, input int first, input int n);
    for (int j = 0; j <= n; j++) begin
      if (j < n) drive(vecs[first+j]);
      else in_valid = 1'b0;
      step();
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      if (j >= 1) begin
        check($sformatf("%s[%0d] valid", tag, j-1), 32'(out_valid), 32'd1);
        check($sformatf("%s[%0d] dst", tag, j-1), 32'(out_dst), 32'(vecs[first+j-1].dst));
        check($sformatf("%s[%0d] data", tag, j-1), out_data, vecs[first+j-1].exp);
      end
    end
    step();
    check({tag, " drained"}, 32'(out_valid), 32'd0);
    exp_retire += n;
    check({tag, " retire_count"}, retire_count, 32'(exp_retire));
  endtask

  initial begin
    // dependent chain
    vecs[0]  = mk(0, 1, 0, 0, 1, 32'd10, 32'd10);
    vecs[1]  = mk(5, 1, 1, 0, 1, 32'd3,  32'd80);
    vecs[2]  = mk(0, 2, 1, 0, 1, 32'd1,  32'd81);
    vecs[3]  = mk(0, 3, 2, 0, 1, 32'd1,  32'd82);
    vecs[4]  = mk(0, 4, 3, 0, 1, 32'd1,  32'd83);
    vecs[5]  = mk(0, 5, 4, 0, 1, 32'd1,  32'd84);
    // zero register
    vecs[6]  = mk(0, 0, 0, 0, 1, 32'd99, 32'd99);
    vecs[7]  = mk(0, 3, 0, 0, 1, 32'd1,  32'd1);
    // arithmetic edges
    vecs[8]  = mk(1, 1,  0, 0, 1, 32'd1,          32'hFFFF_FFFF);
    vecs[9]  = mk(7, 2,  1, 0, 1, 32'd36,         32'hFFFF_FFFF);
    vecs[10] = mk(6, 3,  1, 0, 1, 32'd4,          32'h0FFF_FFFF);
    vecs[11] = mk(8, 4,  1, 0, 0, 32'd0,          32'd1);
    vecs[12] = mk(9, 5,  1, 0, 0, 32'd0,          32'd0);
    vecs[13] = mk(3, 6,  3, 0, 1, 32'hF000_0000,  32'hFFFF_FFFF);
    vecs[14] = mk(2, 7,  3, 0, 1, 32'h00FF_00FF,  32'h00FF_00FF);
    vecs[15] = mk(4, 8,  1, 3, 0, 32'd0,          32'hF000_0000);
    vecs[16] = mk(9, 9,  0, 1, 0, 32'd0,          32'd1);
    vecs[17] = mk(1, 10, 3, 1, 0, 32'd0,          32'h1000_0000);
    vecs[18] = mk(12, 11, 3, 0, 1, 32'd1,         32'h1000_0000);
    vecs[19] = mk(8, 12, 0, 1, 0, 32'd0,          32'd0);
    vecs[20] = mk(5, 13, 3, 0, 1, 32'h24,         32'hFFFF_FFF0);
    vecs[21] = mk(7, 14, 3, 0, 1, 32'd4,          32'h00FF_FFFF);

    reset = 1'b1; in_valid = 1'b0; op = '0; dst = '0; src1 = '0; src2 = '0;
    use_imm = 1'b0; imm = '0; out_ready = 1'b1; dbg_addr = '0;
    p_in_valid = 1'b0; p_op = '0; p_dst = '0; p_src1 = '0; p_src2 = '0;
    p_use_imm = 1'b0; p_imm = '0; p_dbg_addr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_dst", 32'(out_dst), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset retire_count", retire_count, 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    run_table("chain", 0, 6);
    chk_reg("chain x1", 5'd1, 32'd80);
    chk_reg("chain x5", 5'd5, 32'd84);

    // backpressure: second instruction waits in EX behind a stalled WB
    out_ready = 1'b0;
    drive(mk(0, 1, 0, 0, 1, 32'd5, 32'd5)); step();
    drive(mk(0, 2, 1, 0, 1, 32'd2, 32'd7)); step();
    drive(mk(0, 9, 0, 0, 1, 32'd123, 32'd123));
    for (int c = 0; c < 4; c++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_data", out_data, 32'd5);
      check("bp out_dst", 32'(out_dst), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp retire_count", retire_count, 32'(exp_retire));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp release data0", out_data, 32'd5);
    step();
    check("bp release valid1", 32'(out_valid), 32'd1);
    check("bp release data1", out_data, 32'd7);
    step();
    check("bp drained", 32'(out_valid), 32'd0);
    exp_retire += 2;
    check("bp retire_count", retire_count, 32'(exp_retire));
    chk_reg("bp x2", 5'd2, 32'd7);
    chk_reg("bp x9 not accepted", 5'd9, 32'd0);

    run_table("zero", 6, 2);
    chk_reg("zero x0", 5'd0, 32'd0);
    chk_reg("zero x3", 5'd3, 32'd1);

    run_table("arith", 8, 14);
    chk_reg("arith x3", 5'd3, 32'h0FFF_FFFF);
    chk_reg("arith x14", 5'd14, 32'h00FF_FFFF);

    // reset mid-flight
    out_ready = 1'b0;
    drive(mk(0, 6, 0, 0, 1, 32'd7, 32'd7)); step();
    in_valid = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst retire_count", retire_count, 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    chk_reg("rst x6", 5'd6, 32'd0);
    chk_reg("rst x1 cleared", 5'd1, 32'd0);
    out_ready = 1'b1;
    step(); step();
    check("rst later out_valid", 32'(out_valid), 32'd0);
    check("rst later retire_count", retire_count, 32'd0);
    chk_reg("rst later x6", 5'd6, 32'd0);

    // 8-bit build: wrap and shift-amount truncation
    p_in_valid = 1'b1; p_use_imm = 1'b1;
    p_op = 4'd0; p_dst = 3'd7; p_src1 = 3'd0; p_imm = 8'd200; step();
    p_op = 4'd0; p_dst = 3'd7; p_src1 = 3'd7; p_imm = 8'd100; step();
    check("p8 data0", 32'(p_out_data), 32'd200);
    p_op = 4'd5; p_dst = 3'd6; p_src1 = 3'd7; p_imm = 8'd9; step();
    check("p8 data1 wrap", 32'(p_out_data), 32'd44);
    p_in_valid = 1'b0; step();
    check("p8 data2 shl", 32'(p_out_data), 32'd88);
    step();
    p_dbg_addr = 3'd7; #1;
    check("p8 x7", 32'(p_dbg_data), 32'd44);
    p_dbg_addr = 3'd6; #1;
    check("p8 x6", 32'(p_dbg_data), 32'd88);
    check("p8 retire_count", p_retire_count, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
